// File: rtl/ysyx_22050710_ifid_queue.sv
// ysyx_22050710_ifid_queue: fetch-to-decode decoupling FIFO with valid/ready handshake and redirect flush
module ysyx_22050710_ifid_queue #(
    parameter int INST_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_valid,
    input  logic [DATA_WIDTH-1:0] i_if_pc,
    input  logic [INST_WIDTH-1:0] i_if_inst,
    output logic                  o_if_ready,
    output logic                  o_id_valid,
    output logic [DATA_WIDTH-1:0] o_id_pc,
    output logic [INST_WIDTH-1:0] o_id_inst,
    input  logic                  i_id_ready,
    input  logic                  i_flush,
    output logic [CNT_W-1:0]      o_count
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic                  w_enq;
    logic                  w_deq;
    // handshake flags come from registered occupancy only, so decode never reaches fetch combinationally
    always_comb begin
        o_if_ready = r_count != CNT_W'(DEPTH);
        o_id_valid = r_count != '0;
        w_enq      = i_if_valid & o_if_ready & ~i_flush;
        w_deq      = o_id_valid & i_id_ready & ~i_flush;
        o_id_pc    = o_id_valid ? r_pc_mem[r_rd_ptr] : '0;
        o_id_inst  = o_id_valid ? r_inst_mem[r_rd_ptr] : '0;
        o_count    = r_count;
    end
    // pointers and occupancy; reset outranks flush, flush outranks both handshakes
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_enq ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_deq ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count  <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end
    // storage is left unreset; entries are only visible once counted
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_enq) begin
            r_pc_mem[r_wr_ptr]   <= i_if_pc;
            r_inst_mem[r_wr_ptr] <= i_if_inst;
        end
    end
endmodule

// File: tb/tb_ysyx_22050710_ifid_queue.sv
// tb_ysyx_22050710_ifid_queue: vector table, streaming sequence and randomized queue-model check
module tb_ysyx_22050710_ifid_queue;
    localparam int DEPTH = 2;
    logic        clk = 0;
    logic        rst, vld, rdy, fl;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        if_ready, id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic [1:0]  count;
    int n_cmp = 0;
    int n_bad = 0;

    ysyx_22050710_ifid_queue dut (
        .i_clk(clk), .i_rst(rst), .i_if_valid(vld), .i_if_pc(pc), .i_if_inst(inst),
        .o_if_ready(if_ready), .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_inst(id_inst),
        .i_id_ready(rdy), .i_flush(fl), .o_count(count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) assert (count <= DEPTH) else $error("FAIL count_range actual=%0d", count);

    typedef struct {
        logic        rst, vld, rdy, fl;
        logic [63:0] pc;
        logic        er, ev;
        logic [1:0]  ec;
        logic [63:0] ep;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic d, logic f, logic [63:0] p,
                                logic er, logic ev, logic [1:0] ec, logic [63:0] ep);
        vec_t t;
        t.rst = r; t.vld = v; t.rdy = d; t.fl = f; t.pc = p;
        t.er = er; t.ev = ev; t.ec = ec; t.ep = ep;
        return t;
    endfunction

    function automatic logic [31:0] ik(logic [63:0] p);
        return p[31:0] ^ 32'h8000_0413;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic v, logic d, logic f, logic [63:0] p);
        rst = r; vld = v; rdy = d; fl = f; pc = p; inst = ik(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] A = 64'h8000_0000;
    vec_t tbl[20];
    logic [63:0] q[$];

    initial begin
        drive(1, 0, 0, 0, 0);
        tbl[0]  = mk(1, 0, 0, 0, 0,          1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0,          1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,          1, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, A,          1, 1, 1, A);
        tbl[4]  = mk(0, 0, 1, 0, 0,          1, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, A,          1, 1, 1, A);
        tbl[6]  = mk(0, 1, 0, 0, A + 4,      0, 1, 2, A);
        tbl[7]  = mk(0, 1, 0, 0, A + 8,      0, 1, 2, A);
        tbl[8]  = mk(0, 1, 1, 0, A + 8,      1, 1, 1, A + 4);
        tbl[9]  = mk(0, 1, 1, 0, A + 8,      1, 1, 1, A + 8);
        tbl[10] = mk(0, 0, 1, 0, 0,          1, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, A + 'h10,   1, 1, 1, A + 'h10);
        tbl[12] = mk(0, 1, 0, 0, A + 'h14,   0, 1, 2, A + 'h10);
        tbl[13] = mk(0, 1, 0, 1, A + 'h100,  1, 0, 0, 0);
        tbl[14] = mk(0, 1, 0, 0, A + 'h200,  1, 1, 1, A + 'h200);
        tbl[15] = mk(0, 0, 1, 0, 0,          1, 0, 0, 0);
        tbl[16] = mk(0, 1, 0, 0, A + 'h300,  1, 1, 1, A + 'h300);
        tbl[17] = mk(0, 1, 0, 0, A + 'h304,  0, 1, 2, A + 'h300);
        tbl[18] = mk(1, 1, 0, 0, A + 'h308,  1, 0, 0, 0);
        tbl[19] = mk(0, 0, 1, 0, 0,          1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].rdy, tbl[i].fl, tbl[i].pc);
            tick();
            chk($sformatf("vec%0d_ready", i), 64'(if_ready), 64'(tbl[i].er));
            chk($sformatf("vec%0d_valid", i), 64'(id_valid), 64'(tbl[i].ev));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].ec));
            chk($sformatf("vec%0d_pc", i), id_pc, tbl[i].ep);
            chk($sformatf("vec%0d_inst", i), 64'(id_inst), 64'(tbl[i].ev ? ik(tbl[i].ep) : 32'h0));
        end

        // continuous streaming: one beat in, one beat out every cycle after the first
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 1, 0, A + 64'(4 * k));
            tick();
            chk($sformatf("stream%0d_valid", k), 64'(id_valid), 64'd1);
            chk($sformatf("stream%0d_count", k), 64'(count), 64'd1);
            chk($sformatf("stream%0d_pc", k), id_pc, A + 64'(4 * k));
        end
        drive(0, 0, 1, 0, 0);
        tick();
        chk("stream_drain_count", 64'(count), 64'd0);

        // randomized traffic against an ordered-queue reference
        q.delete();
        for (int c = 0; c < 400; c++) begin
            logic r, v, d, f, enq, deq;
            logic [63:0] p;
            r = ($urandom_range(0, 49) == 0);
            f = ($urandom_range(0, 14) == 0);
            v = $urandom_range(0, 3) != 0;
            d = $urandom_range(0, 2) != 0;
            p = {$urandom, $urandom};
            drive(r, v, d, f, p);
            #1;
            chk("rand_ready", 64'(if_ready), 64'(q.size() != DEPTH));
            enq = v && q.size() != DEPTH && !f;
            deq = q.size() != 0 && d && !f;
            if (r || f) q.delete();
            else begin
                if (deq) void'(q.pop_front());
                if (enq) q.push_back(p);
            end
            @(posedge clk);
            #1;
            chk("rand_count", 64'(count), 64'(q.size()));
            chk("rand_valid", 64'(id_valid), 64'(q.size() != 0));
            chk("rand_pc", id_pc, q.size() != 0 ? q[0] : 64'h0);
            chk("rand_inst", 64'(id_inst), 64'(q.size() != 0 ? ik(q[0]) : 32'h0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
